// File: rtl/cv_ctrl_pkg.sv
// rtl/cv_ctrl_pkg.sv - shared mode type, keypad code table and bit positions for cv_ctrl_port
package cv_ctrl_pkg;

  typedef enum logic {
    MODE_KEY = 1'b0,
    MODE_JOY = 1'b1
  } mode_e;

  // Positions within one port's joystick input vector {fire_l, left, down, right, up}
  localparam int JIN_UP    = 0;
  localparam int JIN_RIGHT = 1;
  localparam int JIN_DOWN  = 2;
  localparam int JIN_LEFT  = 3;
  localparam int JIN_FIRE  = 4;

  // Positions within the JOY-format read byte
  localparam int JOY_UP    = 0;
  localparam int JOY_RIGHT = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_LEFT  = 3;
  localparam int JOY_SPIN  = 4;
  localparam int JOY_FIRE  = 6;

  // Key vector per port: bits 9..0 = digits, 10 = '*', 11 = '#', 12 = fire_r
  localparam int KEY_FIRE  = 12;
  localparam int KEY_NONE  = 12;

  localparam logic [3:0] KEY_CODE [0:12] = '{
    4'hA, 4'hD, 4'h7, 4'hC, 4'h2, 4'h3, 4'hE, 4'h5, 4'h1, 4'hB,
    4'h9, 4'h6, 4'hF
  };

  // Lowest pressed key index wins; no key gives the idle code.
  function automatic logic [3:0] key_encode(input logic [11:0] keys);
    logic [3:0] code;
    code = KEY_CODE[KEY_NONE];
    for (int i = 11; i >= 0; i--) begin
      if (keys[i]) code = KEY_CODE[i];
    end
    return code;
  endfunction

endpackage

// File: rtl/cv_quad_dec.sv
// rtl/cv_quad_dec.sv - single-port quadrature decoder on pre-synchronized A/B inputs
// Only instantiated when CV_SPINNER_EN is defined.
module cv_quad_dec (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_i,
  input  logic b_i,
  output logic step_o,
  output logic dir_o
);

  logic [1:0] ab_q;
  logic       dir_q, dir_d;
  logic       a_chg, b_chg, cw;

  assign a_chg  = a_i ^ ab_q[1];
  assign b_chg  = b_i ^ ab_q[0];
  // A double transition changes both bits and is not a valid Gray step.
  assign step_o = a_chg ^ b_chg;
  // Clockwise (A leads B): 00 -> 10 -> 11 -> 01 -> 00
  assign cw     = a_chg ? (a_i ^ ab_q[0]) : ~(b_i ^ ab_q[1]);
  assign dir_o  = dir_q;

  always_comb begin
    dir_d = dir_q;
    if (step_o) dir_d = cw;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ab_q  <= 2'b00;
      dir_q <= 1'b1;
    end else begin
      ab_q  <= {a_i, b_i};
      dir_q <= dir_d;
    end
  end

endmodule

// File: rtl/cv_ctrl_port.sv
// rtl/cv_ctrl_port.sv - dual controller port: mode register, keypad/joystick encode, read latch
// Define CV_SPINNER_EN to add per-port quadrature decoding and the int_n_o interrupt.
module cv_ctrl_port (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ctrl_en_key_n_i,
  input  logic        ctrl_en_joy_n_i,
  input  logic        ctrl_r_n_i,
  input  logic        port_sel_i,
  input  logic [9:0]  joy_i,
  input  logic [25:0] key_i,
  input  logic [1:0]  spin_a_i,
  input  logic [1:0]  spin_b_i,
  output logic [7:0]  d_o,
  output logic        int_n_o
);

  import cv_ctrl_pkg::*;

  logic [9:0]  joy_s1_q, joy_s2_q;
  logic [25:0] key_s1_q, key_s2_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      joy_s1_q <= '0;
      joy_s2_q <= '0;
      key_s1_q <= '0;
      key_s2_q <= '0;
    end else begin
      joy_s1_q <= joy_i;
      joy_s2_q <= joy_s1_q;
      key_s1_q <= key_i;
      key_s2_q <= key_s1_q;
    end
  end

  // Previous strobe levels reset low so a strobe already held low at reset
  // release is not seen as a falling edge.
  logic joy_n_q, key_n_q, rd_n_q;
  logic joy_fall, key_fall, rd_fall;

  assign joy_fall = joy_n_q & ~ctrl_en_joy_n_i;
  assign key_fall = key_n_q & ~ctrl_en_key_n_i;
  assign rd_fall  = rd_n_q  & ~ctrl_r_n_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      joy_n_q <= 1'b0;
      key_n_q <= 1'b0;
      rd_n_q  <= 1'b0;
    end else begin
      joy_n_q <= ctrl_en_joy_n_i;
      key_n_q <= ctrl_en_key_n_i;
      rd_n_q  <= ctrl_r_n_i;
    end
  end

  mode_e mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (key_fall) mode_d = MODE_KEY;
    if (joy_fall) mode_d = MODE_JOY;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) mode_q <= MODE_KEY;
    else         mode_q <= mode_d;
  end

  logic [4:0]  sel_joy;
  logic [12:0] sel_key;
  logic        sel_dir;
  logic [3:0]  key_code;
  logic [7:0]  joy_val, key_val;

  assign sel_joy  = port_sel_i ? joy_s2_q[9:5]   : joy_s2_q[4:0];
  assign sel_key  = port_sel_i ? key_s2_q[25:13] : key_s2_q[12:0];
  assign key_code = key_encode(sel_key[11:0]);

  always_comb begin
    joy_val           = 8'hFF;
    joy_val[JOY_UP]    = ~sel_joy[JIN_UP];
    joy_val[JOY_RIGHT] = ~sel_joy[JIN_RIGHT];
    joy_val[JOY_DOWN]  = ~sel_joy[JIN_DOWN];
    joy_val[JOY_LEFT]  = ~sel_joy[JIN_LEFT];
    joy_val[JOY_SPIN]  = sel_dir;
    joy_val[JOY_FIRE]  = ~sel_joy[JIN_FIRE];
  end

  always_comb begin
    key_val           = 8'hFF;
    key_val[3:0]      = key_code;
    key_val[JOY_FIRE] = ~sel_key[KEY_FIRE];
  end

  logic [7:0] d_q, d_d;

  always_comb begin
    d_d = d_q;
    if (rd_fall) d_d = (mode_q == MODE_JOY) ? joy_val : key_val;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) d_q <= 8'hFF;
    else         d_q <= d_d;
  end

  assign d_o = d_q;

`ifdef CV_SPINNER_EN
  logic [1:0] spa_s1_q, spa_s2_q, spb_s1_q, spb_s2_q;
  logic [1:0] step, dir;
  logic [1:0] pend_q, pend_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      spa_s1_q <= '0;
      spa_s2_q <= '0;
      spb_s1_q <= '0;
      spb_s2_q <= '0;
    end else begin
      spa_s1_q <= spin_a_i;
      spa_s2_q <= spa_s1_q;
      spb_s1_q <= spin_b_i;
      spb_s2_q <= spb_s1_q;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_quad
    cv_quad_dec u_quad (
      .clk_i  (clk_i),
      .rst_i  (reset_i),
      .a_i    (spa_s2_q[p]),
      .b_i    (spb_s2_q[p]),
      .step_o (step[p]),
      .dir_o  (dir[p])
    );
  end

  // A step arriving with the clearing read wins so no movement is lost.
  always_comb begin
    pend_d = pend_q;
    if (rd_fall) pend_d[port_sel_i] = 1'b0;
    pend_d = pend_d | step;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) pend_q <= 2'b00;
    else         pend_q <= pend_d;
  end

  assign sel_dir = port_sel_i ? dir[1] : dir[0];
  assign int_n_o = ~|pend_q;
`else
  logic unused_spin;
  assign unused_spin = ^{spin_a_i, spin_b_i};
  assign sel_dir     = 1'b1;
  assign int_n_o     = 1'b1;
`endif

endmodule

// File: doc/cv_ctrl_port.md
CV_CTRL_PORT -- requirements
Module: cv_ctrl_port

Interface
REQ-001 clk_i  in  1  system clock; all state on rising edge.
REQ-002 reset_i  in  1  asynchronous, active-high reset.
REQ-003 ctrl_en_key_n_i  in  1  keypad-mode select strobe, active low, from the address decoder.
REQ-004 ctrl_en_joy_n_i  in  1  joystick-mode select strobe, active low, from the address decoder.
REQ-005 ctrl_r_n_i  in  1  controller read strobe, active low, from the address decoder.
REQ-006 port_sel_i  in  1  CPU a_i[1]; 0 = port 1, 1 = port 2.
REQ-007 joy_i  in  2x5  per port {fire_l, left, down, right, up}, active high, asynchronous.
REQ-008 key_i  in  2x13  per port {fire_r, '#', '*', '9'..'0'}, active high, asynchronous.
REQ-009 spin_a_i, spin_b_i  in  2 each  per-port quadrature inputs, asynchronous.
REQ-010 d_o  out  8  read data, active-low controller bits.
REQ-011 int_n_o  out  1  spinner interrupt request, active low.

Function
REQ-012 All asynchronous controller inputs SHALL pass through 2-flop synchronizers; functional latency is measured from the synchronized value.
REQ-013 Mode register SHALL be set to JOY on a falling edge of ctrl_en_joy_n_i and to KEY on a falling edge of ctrl_en_key_n_i; if both fall in the same cycle, JOY wins.
REQ-014 Mode SHALL be global to both ports.
REQ-015 On the cycle after a falling edge of ctrl_r_n_i, d_o SHALL load the selected port's value.
REQ-016 d_o SHALL hold that value until the next falling edge of ctrl_r_n_i, ignoring input changes meanwhile.
REQ-017 JOY value: bit0 = ~up, bit1 = ~right, bit2 = ~down, bit3 = ~left, bit4 = spinner direction, bit5 = 1, bit6 = ~fire_l, bit7 = 1.
REQ-018 KEY value: bits3:0 = keypad code, bit6 = ~fire_r; bits 4, 5 and 7 = 1.
REQ-019 Keypad codes: 0=A, 1=D, 2=7, 3=C, 4=2, 5=3, 6=E, 7=5, 8=1, 9=B, *=9, #=6, none=F (hex).
REQ-020 If several keys are pressed, the lowest index (0..9, *, #) SHALL win.
REQ-021 A mode change while ctrl_r_n_i is low SHALL NOT alter d_o until the next read edge.

Reset
REQ-022 Reset SHALL set: mode = KEY, d_o = 8'hFF, int_n_o = 1, synchronizers = 0, spinner state cleared, direction bits = 1.
REQ-023 Reset asserted mid-read SHALL force d_o = 8'hFF immediately.
REQ-024 After reset release, d_o SHALL remain 8'hFF until the first read edge.

Configuration
REQ-025 Macro CV_SPINNER_EN SHALL compile in per-port quadrature decoding and the interrupt logic.
REQ-026 With CV_SPINNER_EN: each valid Gray-code quadrature step SHALL set that port's pending flag and record direction (1 = clockwise, A leads B) in the JOY bit4 value.
REQ-027 With CV_SPINNER_EN: invalid (double) transitions SHALL be ignored.
REQ-028 With CV_SPINNER_EN: int_n_o = ~(pending1 | pending2).
REQ-029 With CV_SPINNER_EN: a read of port N SHALL clear pendingN; a step on port N in the same cycle keeps pendingN set.
REQ-030 Without CV_SPINNER_EN: int_n_o is tied to 1, bit4 is always 1, spin inputs are unused and no spinner flops exist.

Structure
REQ-031 Package cv_ctrl_pkg SHALL hold: mode enum {KEY, JOY}, keypad code constant table, JOY bit-position constants.
REQ-032 Sub-module cv_quad_dec (one instance per port) SHALL contain the quadrature state, step-valid output and direction output.
REQ-033 The remainder (edge detect, mode, encoder, read register, interrupt) SHALL live in cv_ctrl_port.

Verification
REQ-034 Pulse ctrl_en_joy_n_i, hold up+fire_l on port 1, read with port_sel_i=0 -> d_o = 8'hBE one cycle after the read edge.
REQ-035 Pulse ctrl_en_key_n_i, press '5' and '9' on port 2, read with port_sel_i=1 -> d_o = 8'hF3; press fire_r too -> d_o = 8'hB3.
REQ-036 Pulse both mode strobes in the same cycle, then read with all inputs idle -> JOY format, d_o = 8'hFF.
REQ-037 CV_SPINNER_EN: one clockwise step on port 1 -> int_n_o = 0; JOY read of port 1 -> bit4 = 1 and int_n_o = 1 next cycle; step coincident with the read -> int_n_o stays 0.
REQ-038 Assert reset_i during a held read -> d_o = 8'hFF and int_n_o = 1 asynchronously; mode = KEY after release.
REQ-039 Change inputs while ctrl_r_n_i is held low for 10 cycles -> d_o unchanged.
